// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared packet/fragment geometry and RX state encodings
package router_pkg;

    localparam int DATA_WIDTH         = 1024;
    localparam int ADDR_WIDTH         = 10;
    localparam int PKT_WIDTH          = DATA_WIDTH + ADDR_WIDTH + 1 + 2*1 + 2*2;
    localparam int ROUTER_WIDTH       = 2;
    localparam int AURORA_WIDTH       = 256;
    localparam int HDR_WIDTH          = 9;
    localparam int FRAG_PAYLOAD_WIDTH = AURORA_WIDTH - HDR_WIDTH;
    localparam int NUM_FRAGS          = (PKT_WIDTH + FRAG_PAYLOAD_WIDTH - 1) / FRAG_PAYLOAD_WIDTH;

    // Fragments 0..NUM_FRAGS-2 are buffered; the last one lands straight in pkt_out.
    localparam int BUF_WIDTH       = (NUM_FRAGS - 1) * FRAG_PAYLOAD_WIDTH;
    localparam int LAST_FRAG_BITS  = PKT_WIDTH - BUF_WIDTH;

    localparam int SRC_LSB     = 0;
    localparam int DST_LSB     = 2;
    localparam int FNUM_LSB    = 4;
    localparam int TTL_LSB     = 7;
    localparam int PAYLOAD_LSB = 9;
    localparam int FNUM_WIDTH  = 3;
    localparam int TTL_WIDTH   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01
    } rx_state_e;

endpackage

// File: rtl/reassemble_pkt.sv
// rtl/reassemble_pkt.sv - rebuilds PKT_WIDTH-bit packets from 256-bit Aurora fragments
module reassemble_pkt
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [AURORA_WIDTH-1:0] frag_in,
    input  logic                    frag_in_valid,
    input  logic [ROUTER_WIDTH-1:0] my_router,
    output logic [PKT_WIDTH-1:0]    pkt_out,
    output logic                    pkt_out_valid,
    output logic [ROUTER_WIDTH-1:0] pkt_src_router,
    output logic [1:0]              pkt_ttl,
    output logic                    frag_err,
    output logic                    busy
);

    localparam int                  CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FNUM_WIDTH-1:0] LAST_IDX = FNUM_WIDTH'(NUM_FRAGS - 1);

    logic [ROUTER_WIDTH-1:0]       hdr_src;
    logic [ROUTER_WIDTH-1:0]       hdr_dst;
    logic [FNUM_WIDTH-1:0]         hdr_fnum;
    logic [TTL_WIDTH-1:0]          hdr_ttl;
    logic [FRAG_PAYLOAD_WIDTH-1:0] hdr_payload;
    logic                          accept;

    assign hdr_src     = frag_in[SRC_LSB +: ROUTER_WIDTH];
    assign hdr_dst     = frag_in[DST_LSB +: ROUTER_WIDTH];
    assign hdr_fnum    = frag_in[FNUM_LSB +: FNUM_WIDTH];
    assign hdr_ttl     = frag_in[TTL_LSB +: TTL_WIDTH];
    assign hdr_payload = frag_in[PAYLOAD_LSB +: FRAG_PAYLOAD_WIDTH];
    assign accept      = frag_in_valid && (hdr_dst == my_router);

    rx_state_e                 state_q, state_d;
    logic [FNUM_WIDTH-1:0]     expect_q, expect_d;
    logic [BUF_WIDTH-1:0]      buf_q, buf_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ROUTER_WIDTH-1:0]   src_q, src_d;
    logic [TTL_WIDTH-1:0]      ttl_q, ttl_d;
    logic [PKT_WIDTH-1:0]      pkt_out_q, pkt_out_d;
    logic                      pkt_valid_q, pkt_valid_d;
    logic [ROUTER_WIDTH-1:0]   pkt_src_q, pkt_src_d;
    logic [TTL_WIDTH-1:0]      pkt_ttl_q, pkt_ttl_d;
    logic                      frag_err_q, frag_err_d;

    logic in_idle, in_collect;
    logic ev_idle_start, ev_idle_err;
    logic ev_restart, ev_match, ev_complete, ev_store, ev_bad, ev_timeout;
    logic ev_start;

    // Beat classification; every accepted beat falls into exactly one event.
    always_comb begin
        in_idle       = (state_q == ST_IDLE);
        in_collect    = (state_q == ST_COLLECT);
        ev_idle_start = in_idle && accept && (hdr_fnum == '0);
        ev_idle_err   = in_idle && accept && (hdr_fnum != '0);
        ev_restart    = in_collect && accept && (hdr_fnum == '0);
        ev_match      = in_collect && accept && (hdr_fnum != '0)
                        && (hdr_fnum == expect_q) && (hdr_src == src_q);
        ev_complete   = ev_match && (expect_q == LAST_IDX);
        ev_store      = ev_match && (expect_q != LAST_IDX);
        ev_bad        = in_collect && accept && (hdr_fnum != '0) && !ev_match;
        ev_timeout    = in_collect && !accept && (cnt_q == CNT_MAX);
        ev_start      = ev_idle_start || ev_restart;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            expect_q    <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            src_q       <= '0;
            ttl_q       <= '0;
            pkt_out_q   <= '0;
            pkt_valid_q <= 1'b0;
            pkt_src_q   <= '0;
            pkt_ttl_q   <= '0;
            frag_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            expect_q    <= expect_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            ttl_q       <= ttl_d;
            pkt_out_q   <= pkt_out_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_src_q   <= pkt_src_d;
            pkt_ttl_q   <= pkt_ttl_d;
            frag_err_q  <= frag_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ev_idle_start) begin
                    state_d = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (ev_complete || ev_bad || ev_timeout) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        expect_d    = expect_q;
        buf_d       = buf_q;
        src_d       = src_q;
        ttl_d       = ttl_q;
        pkt_out_d   = pkt_out_q;
        pkt_src_d   = pkt_src_q;
        pkt_ttl_d   = pkt_ttl_q;
        pkt_valid_d = ev_complete;
        frag_err_d  = ev_idle_err || ev_restart || ev_bad || ev_timeout;

        // Timer only runs while collecting; any accepted beat restarts the gap.
        if (state_d == ST_COLLECT && in_collect && !accept) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        if (ev_start) begin
            buf_d[0 +: FRAG_PAYLOAD_WIDTH] = hdr_payload;
            src_d    = hdr_src;
            ttl_d    = hdr_ttl;
            expect_d = FNUM_WIDTH'(1);
        end else if (ev_store) begin
            for (int i = 1; i < NUM_FRAGS - 1; i++) begin
                if (expect_q == FNUM_WIDTH'(i)) begin
                    buf_d[i*FRAG_PAYLOAD_WIDTH +: FRAG_PAYLOAD_WIDTH] = hdr_payload;
                end
            end
            expect_d = expect_q + FNUM_WIDTH'(1);
        end else if (state_d == ST_IDLE) begin
            expect_d = '0;
        end

        if (ev_complete) begin
            pkt_out_d = {hdr_payload[LAST_FRAG_BITS-1:0], buf_q};
            pkt_src_d = src_q;
            pkt_ttl_d = ttl_q;
        end
    end

    always_comb begin
        pkt_out        = pkt_out_q;
        pkt_out_valid  = pkt_valid_q;
        pkt_src_router = pkt_src_q;
        pkt_ttl        = pkt_ttl_q;
        frag_err       = frag_err_q;
        busy           = (state_q == ST_COLLECT);
    end

endmodule

// File: doc/reassemble_pkt.md
Name: reassemble_pkt

Overview:
- Receive-side counterpart of the fragmenter. Accepts the 256-bit Aurora fragments arriving from the link and validates each fragment header.
- Rebuilds the full PKT_WIDTH-bit packet (data+addr, ack, seq nums, dfx) and hands it to the decapsulation/ack stage as a single-cycle valid pulse.
- Sits between the Aurora RX FIFO output and the decapsulate-packet block.

Parameters:
- DATA_WIDTH, 1024, packet data width
- ADDR_WIDTH, 10, packet address width
- PKT_WIDTH, 1041, DATA_WIDTH+ADDR_WIDTH+1+2*1+2*2
- ROUTER_WIDTH, 2, router id width
- AURORA_WIDTH, 256, fragment width
- FRAG_PAYLOAD_WIDTH, 247, AURORA_WIDTH-9 (header = TTL 2 + frag_num 3 + dst 2 + src 2)
- NUM_FRAGS, 5, ceil(PKT_WIDTH/FRAG_PAYLOAD_WIDTH); last fragment index = NUM_FRAGS-1
- TIMEOUT_CYCLES, 64, max gap between fragments of one packet

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frag_in  in  AURORA_WIDTH  fragment: [255:9] payload, [8:7] TTL, [6:4] frag_num, [3:2] dst_router, [1:0] src_router
- frag_in_valid  in  1  frag_in valid this cycle; no backpressure, every valid beat must be consumed
- my_router  in  ROUTER_WIDTH  local router id, quasi-static
- pkt_out  out  PKT_WIDTH  reassembled packet, held until the next completion
- pkt_out_valid  out  1  one-cycle pulse, pkt_out new
- pkt_src_router  out  ROUTER_WIDTH  src_router of the delivered packet
- pkt_ttl  out  2  TTL taken from fragment 0 of the delivered packet
- frag_err  out  1  one-cycle pulse on any discarded partial packet
- busy  out  1  high while in COLLECT

Behaviour:
- Reset: all outputs 0, state IDLE, expected index 0, assembly buffer 0, timeout counter 0. Reset mid-packet discards the partial packet silently, with no frag_err.
- Fragment filter: a valid beat with dst != my_router is ignored entirely. It causes no state change, no error and no timer reset.
- IDLE:
  - Accepted frag_num==0: store payload in buffer slice [246:0], latch src and TTL, set expect=1, go to COLLECT.
  - Accepted frag_num!=0: drop the beat, pulse frag_err, stay in IDLE.
- COLLECT, accepted beat:
  - frag_num==expect and src matches latched src: store payload at buffer[expect*247 +: 247], expect++.
  - frag_num==expect==NUM_FRAGS-1: only bits [PKT_WIDTH-1-4*247:0] of the payload are used (53 bits); upper payload bits are don't-care. Completion fires on this same edge.
  - frag_num==0: pulse frag_err, restart the collection with this fragment (stay in COLLECT, expect=1).
  - Any other mismatch (wrong index, index>4, src differs): pulse frag_err, discard, go to IDLE.
- Completion: on the edge that accepts the last fragment, register pkt_out = {last 53 bits, buffer[987:0]}, pkt_out_valid=1, pkt_src_router and pkt_ttl updated, state to IDLE.
  - Latency: pkt_out_valid is high in the cycle after the final fragment's valid beat.
  - A fragment 0 arriving in that next cycle is accepted normally (back-to-back packets, zero bubble).
- Timeout: the counter clears on every accepted beat while in COLLECT and increments otherwise.
  - Reaching TIMEOUT_CYCLES-1 with no accepted beat: pulse frag_err, go to IDLE.
  - A beat accepted on the timeout cycle itself wins; no timeout fires.
- frag_err and pkt_out_valid never assert in the same cycle.
- TTL is not checked here; forwarding/decrement belongs to the routing stage.

Decomposition:
- Shared router package (router_pkg): PKT_WIDTH derivation, FRAG_PAYLOAD_WIDTH, NUM_FRAGS, header bit offsets (SRC_LSB=0, DST_LSB=2, FNUM_LSB=4, TTL_LSB=7, PAYLOAD_LSB=9), state encodings IDLE=2'b00, COLLECT=2'b01. Fragmenter and reassembler share these.
- No sub-module required; header decode is plain slicing. Timeout counter and state machine stay inline.

Test Plan:
- In-order packet: my_router=2'b01; send frags 0..4 from src=2'b10 carrying a random 1041-bit packet P, one per cycle -> pkt_out==P, pkt_out_valid exactly 1 cycle after frag 4, pkt_src_router=2'b10, frag_err never high.
- Back-to-back with gaps: two packets, frag 0 of the second arrives the cycle after the first's frag 4; random 0-10 cycle gaps inside each -> two valid pulses, both packets exact.
- Foreign traffic: interleave beats with dst=2'b11 between own fragments -> foreign beats ignored, own packet delivered intact, no frag_err.
- Sequence errors: frag 0,1,3 -> frag_err on the frag-3 cycle+1, busy=0; then frag 0,1, frag 0 -> frag_err and restart, completing with frags 1..4 -> correct packet.
- Timeout: frags 0,1 then silence for 64 cycles -> frag_err one cycle, back to IDLE; a fragment on cycle 63 instead -> no error.
- Reset mid-packet: rst_n low after frag 2 -> all outputs 0, no frag_err; a full packet afterwards is delivered correctly.
